instruction_memory_loader: RTL and testbench

Boot-time writer for the instruction memory: accepts a length-prefixed byte stream over a valid/ready handshake, packs big-endian bytes into 32-bit MIPS instruction words, and drives the instruction memory's write port at sequential word addresses from 0. It sits beside the instruction fetch unit on the memory's write side. It also holds the core in reset until a load completes, so fetch never reads a partially loaded program.

---
 rtl/instruction_memory_loader.sv | 123 ++++++++++++
 tb/tb_instruction_memory_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> 32-bit instruction memory writes from address 0.
// One write cycle per 4 accepted bytes; byte_ready drops in IDLE and WRITE, and the loader waits indefinitely on byte_valid.
module instruction_memory_loader #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DEPTH         = 1024
) (
  input  logic                     system_clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [31:0]              write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     cpu_hold
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE} state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state, state_next;
  logic [15:0] length;
  logic [15:0] word_index;
  logic [1:0]  byte_count;
  logic [31:0] assembly;
  logic        accept;
  logic        in_range;
  logic        last_word;

  assign accept    = byte_valid && byte_ready;
  assign in_range  = {1'b0, word_index} < DEPTH_W;
  assign last_word = ({1'b0, word_index} + 17'd1) == {1'b0, length};

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    byte_ready   = 1'b0;
    write_enable = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (accept) state_next = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (accept) state_next = ({length[15:8], byte_data} == 16'd0) ? IDLE : DATA;
      end
      DATA: begin
        byte_ready = 1'b1;
        if (accept && byte_count == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        write_enable = in_range;
        state_next   = last_word ? IDLE : DATA;
      end
      default: state_next = IDLE;
    endcase
  end

  // Out-of-range words still advance word_index so the stream is consumed in full.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      length     <= 16'd0;
      word_index <= 16'd0;
      byte_count <= 2'd0;
      assembly   <= 32'd0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_index <= 16'd0;
          end
        end
        LEN_HI: begin
          if (accept) length[15:8] <= byte_data;
        end
        LEN_LO: begin
          if (accept) begin
            length[7:0] <= byte_data;
            byte_count  <= 2'd0;
            if ({length[15:8], byte_data} == 16'd0) done <= 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            assembly   <= {assembly[23:0], byte_data};
            byte_count <= byte_count + 2'd1;
          end
        end
        WRITE: begin
          if (!in_range) overflow <= 1'b1;
          word_index <= word_index + 16'd1;
          byte_count <= 2'd0;
          if (last_word) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign write_address = ADDRESS_WIDTH'(word_index);
  assign write_data    = assembly;
  assign cpu_hold      = !done;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader (DEPTH=2 so the overflow path is reachable).
module tb_instruction_memory_loader;

  logic        system_clock;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        write_enable;
  logic [9:0]  write_address;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        cpu_hold;

  int tests = 0;
  int fails = 0;

  logic [41:0] wq[$];
  logic        chk_ready = 1'b0;
  int          ready_bad = 0;

  instruction_memory_loader #(.ADDRESS_WIDTH(10), .DEPTH(2)) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .cpu_hold     (cpu_hold)
  );

  initial begin
    system_clock = 1'b0;
    forever #5 system_clock = ~system_clock;
  end

  // Capture every write strobe; while chk_ready is set, byte_ready must be low only in write cycles.
  always @(negedge system_clock) begin
    if (write_enable === 1'b1) wq.push_back({write_address, write_data});
    if (chk_ready && busy === 1'b1 && byte_ready === write_enable) ready_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, write_enable}, 32'd0);
    check({tag, "_addr"},  {22'd0, write_address}, 32'd0);
    check({tag, "_data"},  write_data, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got        = 1'b0;
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge system_clock);
      if (byte_ready === 1'b1) begin
        @(posedge system_clock);
        #1;
        got = 1'b1;
      end
    end
    check("byte_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge system_clock);
    #1;
    start = 1'b0;
    check("start_busy",  {31'd0, busy}, 32'd1);
    check("start_ready", {31'd0, byte_ready}, 32'd1);
    check("start_done",  {31'd0, done}, 32'd0);
    check("start_ovf",   {31'd0, overflow}, 32'd0);
  endtask

  logic [7:0] two_word[10];
  logic [7:0] ovf_stream[14];

  initial begin
    two_word   = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04};
    ovf_stream = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                   8'h99, 8'hAA, 8'hBB, 8'hCC};
    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2 reset = 1'b1;
    #1 check_reset_values("rst");
    repeat (2) @(posedge system_clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge system_clock);
    #1;
    check("idle_hold",  {31'd0, cpu_hold}, 32'd1);
    check("idle_ready", {31'd0, byte_ready}, 32'd0);

    // Two-word load, continuous valid.
    wq.delete();
    do_start();
    for (int i = 0; i < 10; i++) send_byte(two_word[i]);
    byte_valid = 1'b0;
    @(negedge system_clock);
    check("tw_we",    {31'd0, write_enable}, 32'd1);
    check("tw_ready", {31'd0, byte_ready}, 32'd0);
    check("tw_done0", {31'd0, done}, 32'd0);
    check("tw_busy0", {31'd0, busy}, 32'd1);
    @(posedge system_clock);
    #1;
    check("tw_done",  {31'd0, done}, 32'd1);
    check("tw_hold",  {31'd0, cpu_hold}, 32'd0);
    check("tw_busy",  {31'd0, busy}, 32'd0);
    check("tw_we_off", {31'd0, write_enable}, 32'd0);
    check("tw_ovf",   {31'd0, overflow}, 32'd0);
    check("tw_cnt",   wq.size(), 32'd2);
    check("tw_a0",    {22'd0, wq[0][41:32]}, 32'd0);
    check("tw_d0",    wq[0][31:0], 32'h20080005);
    check("tw_a1",    {22'd0, wq[1][41:32]}, 32'd1);
    check("tw_d1",    wq[1][31:0], 32'h8C010004);

    // Zero length.
    wq.delete();
    do_start();
    send_byte(8'h00);
    send_byte(8'h00);
    byte_valid = 1'b0;
    check("z_done",  {31'd0, done}, 32'd1);
    check("z_busy",  {31'd0, busy}, 32'd0);
    check("z_hold",  {31'd0, cpu_hold}, 32'd0);
    repeat (2) @(posedge system_clock);
    #1;
    check("z_ready", {31'd0, byte_ready}, 32'd0);
    check("z_cnt",   wq.size(), 32'd0);

    // Gapped valid (1,0,0,1) with a spurious start mid-load.
    wq.delete();
    do_start();
    ready_bad = 0;
    chk_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_byte(two_word[i]);
      byte_valid = 1'b0;
      if (i == 5) begin
        start = 1'b1;
        @(posedge system_clock);
        #1;
        start = 1'b0;
        check("g_busy_xstart", {31'd0, busy}, 32'd1);
        @(posedge system_clock);
        #1;
      end else if (i < 9) begin
        repeat (2) @(posedge system_clock);
        #1;
      end
    end
    @(posedge system_clock);
    #1;
    chk_ready = 1'b0;
    check("g_done",  {31'd0, done}, 32'd1);
    check("g_rdy",   ready_bad, 32'd0);
    check("g_cnt",   wq.size(), 32'd2);
    check("g_a0",    {22'd0, wq[0][41:32]}, 32'd0);
    check("g_d0",    wq[0][31:0], 32'h20080005);
    check("g_a1",    {22'd0, wq[1][41:32]}, 32'd1);
    check("g_d1",    wq[1][31:0], 32'h8C010004);

    // Overflow: three words into a two-word memory.
    wq.delete();
    do_start();
    for (int i = 0; i < 14; i++) send_byte(ovf_stream[i]);
    byte_valid = 1'b0;
    @(negedge system_clock);
    check("o_we3",   {31'd0, write_enable}, 32'd0);
    check("o_busy3", {31'd0, busy}, 32'd1);
    check("o_ovf0",  {31'd0, overflow}, 32'd0);
    @(posedge system_clock);
    #1;
    check("o_ovf",   {31'd0, overflow}, 32'd1);
    check("o_done",  {31'd0, done}, 32'd1);
    check("o_cnt",   wq.size(), 32'd2);
    check("o_a0",    {22'd0, wq[0][41:32]}, 32'd0);
    check("o_d0",    wq[0][31:0], 32'h11223344);
    check("o_a1",    {22'd0, wq[1][41:32]}, 32'd1);
    check("o_d1",    wq[1][31:0], 32'h55667788);

    // Reset mid-word, then a fresh one-word load.
    wq.delete();
    do_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_valid = 1'b0;
    @(negedge system_clock);
    reset = 1'b1;
    #1 check_reset_values("mid");
    @(posedge system_clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge system_clock);
    #1;
    check("mid_cnt",  wq.size(), 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    do_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    byte_valid = 1'b0;
    @(negedge system_clock);
    check("f_we",   {31'd0, write_enable}, 32'd1);
    @(posedge system_clock);
    #1;
    check("f_done", {31'd0, done}, 32'd1);
    check("f_cnt",  wq.size(), 32'd1);
    check("f_a0",   {22'd0, wq[0][41:32]}, 32'd0);
    check("f_d0",   wq[0][31:0], 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
